// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states,
// lane widths and the access legality check used at request acceptance.
package mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [3:0] {
    IDLE,
    RD_WAIT,
    CAPTURE,
    WRITE,
    RMW_WAIT,
    MERGE,
    RMW_WR,
    DONE,
    ERR
  } state_e;

  // An access is rejected when its size is illegal or its address is not
  // naturally aligned for that size. Bytes are always aligned.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] a_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_WORD: bad = (a_lo != 2'b00);
      SZ_HALF: bad = a_lo[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lane_merge.sv
// Combinational lane logic: extracts and extends the addressed lane of a
// memory word for loads, and splices store data into that lane for
// read-modify-write stores. Little-endian: byte lane k is bits [8k+7:8k].
module lane_merge
  import mem_pkg::*;
(
  input  logic [WORD_W-1:0] mem_word_i,
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] load_o,
  output logic [WORD_W-1:0] merge_o
);

  logic [BYTE_W-1:0] byte_lane;
  logic [HALF_W-1:0] half_lane;
  logic              ext_bit;

  // Lane select, load extension and store merge in one pass.
  always_comb begin
    byte_lane = '0;
    half_lane = '0;
    ext_bit   = 1'b0;
    load_o    = mem_word_i;
    merge_o   = mem_word_i;

    case (addr_lo_i)
      2'd0:    byte_lane = mem_word_i[7:0];
      2'd1:    byte_lane = mem_word_i[15:8];
      2'd2:    byte_lane = mem_word_i[23:16];
      default: byte_lane = mem_word_i[31:24];
    endcase
    half_lane = addr_lo_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];

    case (size_i)
      SZ_BYTE: begin
        ext_bit = ~uns_i & byte_lane[BYTE_W-1];
        load_o  = {{(WORD_W-BYTE_W){ext_bit}}, byte_lane};
        case (addr_lo_i)
          2'd0:    merge_o[7:0]   = wdata_i[7:0];
          2'd1:    merge_o[15:8]  = wdata_i[7:0];
          2'd2:    merge_o[23:16] = wdata_i[7:0];
          default: merge_o[31:24] = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        ext_bit = ~uns_i & half_lane[HALF_W-1];
        load_o  = {{(WORD_W-HALF_W){ext_bit}}, half_lane};
        if (addr_lo_i[1]) merge_o[31:16] = wdata_i[15:0];
        else              merge_o[15:0]  = wdata_i[15:0];
      end
      default: begin
        load_o  = mem_word_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side load/store unit in front of a fixed-latency word memory.
// Handshake: a request is taken only when busy=0 and req=1 on a rising
// edge; the unit then ignores req until it has pulsed done (with err on a
// rejected access) and spent one cycle back in IDLE. Sub-word stores are
// done as read-modify-write of the containing word.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] LAT3 = 3'(READ_LAT);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [31:0] load_word;
  logic [31:0] merge_word;

  lane_merge u_lane_merge (
    .mem_word_i (mem_rdata),
    .size_i     (size_q),
    .uns_i      (uns_q),
    .addr_lo_i  (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .load_o     (load_word),
    .merge_o    (merge_word)
  );

  // State, counter, request fields and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rdata_q     <= rdata_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state logic; request fields are loaded only on acceptance.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rdata_d     = rdata_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          we_d    = we;
          size_d  = size;
          uns_d   = uns;
          if (access_bad(size, addr[1:0])) begin
            state_d = ERR;
          end else if (!we) begin
            state_d = RD_WAIT;
            cnt_d   = LAT3;
          end else if (size == SZ_WORD) begin
            state_d     = WRITE;
            mem_wdata_d = wdata;
          end else begin
            state_d = RMW_WAIT;
            cnt_d   = LAT3;
          end
        end
      end
      // Both wait states share the down-counter; the stored direction picks
      // where the returning read word is consumed.
      RD_WAIT, RMW_WAIT: begin
        if (cnt_q <= 3'd1) begin
          cnt_d   = '0;
          state_d = we_q ? MERGE : CAPTURE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      CAPTURE: begin
        rdata_d = load_word;
        state_d = DONE;
      end
      WRITE:   state_d = DONE;
      MERGE: begin
        mem_wdata_d = merge_word;
        state_d     = RMW_WR;
      end
      RMW_WR:  state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE) || (state_q == ERR);
  assign err       = (state_q == ERR);
  assign mem_wr    = (state_q == WRITE) || (state_q == RMW_WR);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one parameter: READ_LAT, default 1, memory read latency in cycles (1..7) from mem_addr valid to mem_rdata valid.
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  1  CPU access request, sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 word, 01 halfword, 10 byte, 11 illegal.
- uns  in  1  load zero-extends when 1, sign-extends when 0.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified for sub-word stores.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with done on a rejected access.
- rdata  out  32  extended load result, held until the next load completes.
- mem_addr  out  32  word-aligned memory address.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  32  word written to memory.
- mem_rdata  in  32  memory read word.

Function
REQ-003 In IDLE with req=1 the block SHALL register addr, wdata, we, size and uns, and SHALL leave IDLE on the same edge.
REQ-004 States SHALL be IDLE, RD_WAIT, CAPTURE, WRITE, RMW_WAIT, MERGE, RMW_WR, DONE, ERR.
REQ-005 From IDLE, transitions SHALL be:
- illegal or misaligned access -> ERR;
- load -> RD_WAIT;
- word store -> WRITE;
- half or byte store -> RMW_WAIT.
REQ-006 Misaligned SHALL mean: size=00 with addr[1:0]!=0, or size=01 with addr[0]=1; size=11 is illegal.
REQ-007 ERR SHALL assert done=1 and err=1 for one cycle, SHALL perform no memory access, SHALL leave rdata unchanged, and SHALL return to IDLE.
REQ-008 mem_addr SHALL equal {addr_q[31:2],2'b00} in all states, and 0 after reset until the first accepted request.
REQ-009 RD_WAIT and RMW_WAIT SHALL each last exactly READ_LAT cycles, counted by a 3-bit down-counter.
REQ-010 CAPTURE SHALL sample mem_rdata and extract the lane; DONE SHALL follow. Load latency from the accepting edge to the done cycle SHALL be READ_LAT+2 cycles.
REQ-011 Byte order SHALL be little-endian:
- byte lane k = bits [8k+7:8k], selected by addr_q[1:0];
- halfword lane = bits [15:0] when addr_q[1]=0, else bits [31:16].
REQ-012 Load extension SHALL replicate the lane MSB when uns=0 and zero-fill when uns=1; word loads SHALL pass through unchanged.
REQ-013 WRITE SHALL assert mem_wr=1 for exactly one cycle with mem_wdata=wdata_q; DONE SHALL follow (latency 2).
REQ-014 MERGE SHALL replace only the addressed lane of the captured mem_rdata with wdata_q[7:0] or wdata_q[15:0].
REQ-015 RMW_WR SHALL assert mem_wr=1 for one cycle with the merged word; DONE SHALL follow (latency READ_LAT+3).
REQ-016 mem_wr SHALL be 0 in every state other than WRITE and RMW_WR.
REQ-017 DONE SHALL pulse done=1 with err=0 for one cycle and return to IDLE. A req present during the DONE cycle SHALL be ignored; it is accepted only in the following IDLE cycle.
REQ-018 req changes while busy=1 SHALL have no effect; the registered request SHALL complete unaltered.

Reset
REQ-019 On a clk edge with reset=0:
- state SHALL become IDLE;
- busy, done, err, mem_wr, mem_addr, mem_wdata, rdata, the counter and all registered request fields SHALL become 0.
REQ-020 Reset during any state, including RMW_WAIT before RMW_WR, SHALL abort the access with no subsequent mem_wr and no done pulse.

Structure
REQ-021 A shared package mem_pkg SHALL hold:
- the size encodings SZ_WORD, SZ_HALF, SZ_BYTE;
- the state enumeration;
- the lane-width constants.
REQ-022 Lane extraction, extension and merge SHALL be one combinational sub-module, lane_merge, instantiated once. The FSM, counter and output registers SHALL remain in mem_access_unit.

Verification
REQ-023 The bench SHALL cover these directed scenarios (READ_LAT=1 unless stated):
- Memory word 0x0000_0010 = 0x8899AABB; load byte, addr 0x11, uns=0 -> done 3 cycles after acceptance, rdata=0xFFFFFFAA, mem_wr never 1.
- Same word; load half, addr 0x12, uns=1 -> rdata=0x00008899.
- Store byte 0x55 to addr 0x13 -> one mem_wr, mem_wdata=0x5599AABB at mem_addr 0x10, done 4 cycles after acceptance.
- Store word 0x12345678 to addr 0x22 -> err=1 and done=1 in the same cycle, no mem_wr, rdata unchanged.
- READ_LAT=3, store half 0xBEEF to addr 0x10 over 0x8899AABB -> mem_wdata=0x8899BEEF, done 6 cycles after acceptance. Rerun with reset=0 in the RMW_WAIT cycle -> no mem_wr, busy=0 next cycle.
- req held high across back-to-back word loads -> second access accepted only after the IDLE cycle following done, and the first load's rdata held until the second done.
